// File: rtl/m_seq_pkg.sv
// Shared definitions for the 8-bit m-sequence checker: generator polynomial,
// FSM state encoding and the one-step prediction function.
package m_seq_pkg;

  localparam int unsigned LFSR_W = 8;

  // Tap mask over a history word whose bit 0 is the newest bit and bit 7 the
  // oldest: s[n] = s[n-8] ^ s[n-4] ^ s[n-3] ^ s[n-2].
  localparam logic [LFSR_W-1:0] POLY = 8'b10001110;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // Predicted next bit given the last LFSR_W bits (bit 0 = most recent).
  function automatic logic m_seq_next(input logic [LFSR_W-1:0] history);
    return ^(history & POLY);
  endfunction

endpackage

// File: rtl/m_seq_local_gen.sv
// Local m-sequence generator used as the receive-side reference.
//   sclk, rst_n : clock, asynchronous active-low reset
//   load        : load the generator window from load_val (takes priority)
//   load_val    : last 8 received bits, bit 0 newest
//   adv         : advance the generator by one bit
//   pred        : registered prediction of the next sequence bit
module m_seq_local_gen
  import m_seq_pkg::*;
(
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              adv,
  output logic              pred
);

  // The 8-bit window is the 7 most recent bits plus the pending prediction;
  // the oldest bit is consumed by the prediction and need not be stored.
  logic [LFSR_W-2:0] win_q;
  logic [LFSR_W-1:0] win_adv_c;

  assign win_adv_c = {win_q, pred};

  // Window and prediction registers.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
      pred  <= 1'b0;
    end else if (load) begin
      win_q <= load_val[LFSR_W-2:0];
      pred  <= m_seq_next(load_val);
    end else if (adv) begin
      win_q <= win_adv_c[LFSR_W-2:0];
      pred  <= m_seq_next(win_adv_c);
    end
  end

endmodule

// File: rtl/m_seq_checker.sv
// Receive-side checker for the 8-bit m-sequence (POLY 8'b10001110).
// Self-synchronises a local generator to the incoming stream, declares lock,
// then counts checked bits and bit errors and detects loss of sync.
//   sclk, rst_n : clock, asynchronous active-low reset
//   din_valid   : qualifies din
//   din         : received sequence bit
//   clr_cnt     : synchronous clear of bit_cnt / err_cnt (wins over increment)
//   locked      : high while locked
//   err_pulse   : one-cycle pulse per mismatching bit while locked
//   sync_loss   : one-cycle pulse on the locked-to-hunt transition
//   bit_cnt     : saturating count of bits checked while locked
//   err_cnt     : saturating count of mismatches while locked
module m_seq_checker
  import m_seq_pkg::*;
#(
  parameter int unsigned SYNC_THRESH = 16,
  parameter int unsigned WINDOW      = 64,
  parameter int unsigned LOSS_THRESH = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             sclk,
  input  logic             rst_n,
  input  logic             din_valid,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             sync_loss,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned FILL_W = $clog2(LFSR_W + 1);
  localparam int unsigned MCNT_W = $clog2(SYNC_THRESH + 1);
  localparam int unsigned WIN_W  = $clog2(WINDOW);
  localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

  state_e              state_q;
  state_e              state_nx;
  logic [LFSR_W-2:0]   hist_q;
  logic [FILL_W-1:0]   fill_q;
  logic [MCNT_W-1:0]   mcnt_q;
  logic [WIN_W-1:0]    win_cnt_q;
  logic [WERR_W-1:0]   win_err_q;
  logic                gen_pred;

  // Status terms shared by the next-state and output decode.
  logic [LFSR_W-1:0]   hist_new_c;
  logic                hist_nz_c;
  logic                fill_full_c;
  logic                match_c;
  logic                verify_done_c;
  logic                loss_hit_c;
  logic                win_wrap_c;

  // Control decode.
  logic                gen_load_c;
  logic                gen_adv_c;
  logic                fill_inc_c;
  logic                fill_clr_c;
  logic                mcnt_inc_c;
  logic                mcnt_clr_c;
  logic                win_clr_c;
  logic                chk_c;
  logic                err_c;
  logic                loss_c;

  // History including the bit currently on din; only 7 bits are stored since
  // every use of the full 8-bit history coincides with a valid bit.
  assign hist_new_c    = {hist_q, din};
  assign hist_nz_c     = |hist_new_c;
  assign fill_full_c   = fill_q >= FILL_W'(LFSR_W - 1);
  assign match_c       = din == gen_pred;
  assign verify_done_c = mcnt_q == MCNT_W'(SYNC_THRESH - 1);
  assign loss_hit_c    = win_err_q == WERR_W'(LOSS_THRESH - 1);
  assign win_wrap_c    = win_cnt_q == WIN_W'(WINDOW - 1);

  m_seq_local_gen u_gen (
    .sclk     (sclk),
    .rst_n    (rst_n),
    .load     (gen_load_c),
    .load_val (hist_new_c),
    .adv      (gen_adv_c),
    .pred     (gen_pred)
  );

  // State register.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) state_q <= HUNT;
    else        state_q <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      HUNT: begin
        if (din_valid && fill_full_c && hist_nz_c) state_nx = VERIFY;
      end
      VERIFY: begin
        if (din_valid) begin
          if (match_c) begin
            if (verify_done_c) state_nx = LOCKED;
          end else if (!hist_nz_c) begin
            state_nx = HUNT;
          end
        end
      end
      LOCKED: begin
        if (din_valid && !match_c && loss_hit_c) state_nx = HUNT;
      end
      default: state_nx = HUNT;
    endcase
  end

  // Output / control decode.
  always_comb begin
    gen_load_c = 1'b0;
    gen_adv_c  = 1'b0;
    fill_inc_c = 1'b0;
    fill_clr_c = 1'b0;
    mcnt_inc_c = 1'b0;
    mcnt_clr_c = 1'b0;
    win_clr_c  = 1'b0;
    chk_c      = 1'b0;
    err_c      = 1'b0;
    loss_c     = 1'b0;
    unique case (state_q)
      HUNT: begin
        mcnt_clr_c = 1'b1;
        fill_inc_c = din_valid;
        gen_load_c = din_valid && fill_full_c && hist_nz_c;
      end
      VERIFY: begin
        if (din_valid) begin
          if (match_c) begin
            gen_adv_c  = 1'b1;
            mcnt_inc_c = 1'b1;
            win_clr_c  = verify_done_c;
          end else begin
            // Re-seed from what was actually received, current bit included.
            gen_load_c = 1'b1;
            mcnt_clr_c = 1'b1;
            fill_clr_c = !hist_nz_c;
          end
        end
      end
      LOCKED: begin
        mcnt_clr_c = 1'b1;
        if (din_valid) begin
          // Flywheel: never reload from din, so a line error counts once.
          gen_adv_c = 1'b1;
          chk_c     = 1'b1;
          if (!match_c) begin
            err_c = 1'b1;
            if (loss_hit_c) begin
              loss_c     = 1'b1;
              fill_clr_c = 1'b1;
            end
          end
        end
      end
      default: mcnt_clr_c = 1'b1;
    endcase
  end

  // History, fill and match counters.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      mcnt_q <= '0;
    end else begin
      if (din_valid) hist_q <= hist_new_c[LFSR_W-2:0];
      if (fill_clr_c) fill_q <= '0;
      else if (fill_inc_c && fill_q != FILL_W'(LFSR_W)) fill_q <= fill_q + FILL_W'(1);
      if (mcnt_clr_c) mcnt_q <= '0;
      else if (mcnt_inc_c) mcnt_q <= mcnt_q + MCNT_W'(1);
    end
  end

  // Loss-detection window; loss takes precedence over the window wrap.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else if (win_clr_c) begin
      win_cnt_q <= '0;
      win_err_q <= '0;
    end else if (chk_c) begin
      if (loss_c || win_wrap_c) begin
        win_cnt_q <= '0;
        win_err_q <= '0;
      end else begin
        win_cnt_q <= win_cnt_q + WIN_W'(1);
        win_err_q <= win_err_q + WERR_W'(err_c);
      end
    end
  end

  // Saturating BER counters and registered status outputs.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      err_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      if (clr_cnt) bit_cnt <= '0;
      else if (chk_c && bit_cnt != '1) bit_cnt <= bit_cnt + CNT_W'(1);
      if (clr_cnt) err_cnt <= '0;
      else if (err_c && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      locked    <= state_nx == LOCKED;
      err_pulse <= err_c;
      sync_loss <= loss_c;
    end
  end

endmodule

// File: tb/tb_m_seq_checker.sv
// Directed bench for m_seq_checker: a table of stream segments with expected
// end-of-segment status, followed by hand-written clear and reset sequences.
module tb_m_seq_checker;

  localparam int unsigned CNT_W = 32;

  logic             sclk = 1'b0;
  logic             rst_n;
  logic             din_valid;
  logic             din;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             sync_loss;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  always #5 sclk = ~sclk;

  m_seq_checker #(
    .SYNC_THRESH (16),
    .WINDOW      (64),
    .LOSS_THRESH (8),
    .CNT_W       (CNT_W)
  ) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .din_valid (din_valid),
    .din       (din),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .sync_loss (sync_loss),
    .bit_cnt   (bit_cnt),
    .err_cnt   (err_cnt)
  );

  typedef struct {
    logic        do_rst;      // reset before the segment
    logic        zero;        // send all-zero data instead of the sequence
    logic        gapped;      // random idle cycles between valid bits
    int unsigned nbits;       // valid bits in the segment
    int unsigned flip_every;  // invert every k-th bit (0 = none)
    int unsigned flip_cnt;    // at most this many inversions
    logic        exp_locked;
    int unsigned exp_bits;
    int unsigned exp_errs;
    int unsigned exp_pulses;  // err_pulse count seen during the segment
    int unsigned exp_losses;  // sync_loss count seen during the segment
  } seg_t;

  localparam int NSEG = 18;
  seg_t segs [NSEG];

  logic        ref_seq [255];
  int unsigned stream_idx;
  int          checks;
  int          failures;
  int unsigned pulse_total;
  int unsigned loss_total;

  function automatic seg_t mk(input logic r, input logic z, input logic g,
                              input int unsigned n, input int unsigned fe,
                              input int unsigned fc, input logic el,
                              input int unsigned eb, input int unsigned ee,
                              input int unsigned ep, input int unsigned es);
    seg_t s;
    s.do_rst = r; s.zero = z; s.gapped = g; s.nbits = n;
    s.flip_every = fe; s.flip_cnt = fc; s.exp_locked = el;
    s.exp_bits = eb; s.exp_errs = ee; s.exp_pulses = ep; s.exp_losses = es;
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic tick(input logic v, input logic d, input logic c);
    @(negedge sclk);
    din_valid = v;
    din       = d;
    clr_cnt   = c;
    @(posedge sclk);
    #1;
    if (err_pulse) pulse_total++;
    if (sync_loss) loss_total++;
  endtask

  task automatic next_bit(output logic b);
    b = ref_seq[stream_idx];
    stream_idx = (stream_idx + 1) % 255;
  endtask

  task automatic do_reset(input string tag);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    din       = 1'b0;
    clr_cnt   = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    check({tag, " rst locked"},    64'(locked),    64'd0);
    check({tag, " rst err_pulse"}, 64'(err_pulse), 64'd0);
    check({tag, " rst sync_loss"}, 64'(sync_loss), 64'd0);
    check({tag, " rst bit_cnt"},   64'(bit_cnt),   64'd0);
    check({tag, " rst err_cnt"},   64'(err_cnt),   64'd0);
    @(negedge sclk);
    rst_n = 1'b1;
    stream_idx = 0;
  endtask

  task automatic run_seg(input int k, input seg_t s);
    int unsigned p0;
    int unsigned l0;
    logic d;
    string tag;
    tag = $sformatf("seg%0d", k);
    if (s.do_rst) do_reset(tag);
    p0 = pulse_total;
    l0 = loss_total;
    for (int unsigned i = 1; i <= s.nbits; i++) begin
      if (s.gapped)
        for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++)
          tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      if (s.zero) begin
        d = 1'b0;
      end else begin
        next_bit(d);
        if (s.flip_every != 0 && i % s.flip_every == 0 && i / s.flip_every <= s.flip_cnt)
          d = ~d;
      end
      tick(1'b1, d, 1'b0);
    end
    check({tag, " locked"},  64'(locked),            64'(s.exp_locked));
    check({tag, " bit_cnt"}, 64'(bit_cnt),           64'(s.exp_bits));
    check({tag, " err_cnt"}, 64'(err_cnt),           64'(s.exp_errs));
    check({tag, " pulses"},  64'(pulse_total - p0),  64'(s.exp_pulses));
    check({tag, " losses"},  64'(loss_total - l0),   64'(s.exp_losses));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic d;
    rst_n = 1'b0; din_valid = 1'b0; din = 1'b0; clr_cnt = 1'b0;
    checks = 0; failures = 0; pulse_total = 0; loss_total = 0; stream_idx = 0;

    // Reference stream straight from the recurrence, all-ones seed.
    for (int i = 0; i < 8; i++) ref_seq[i] = 1'b1;
    for (int i = 8; i < 255; i++)
      ref_seq[i] = ref_seq[i-8] ^ ref_seq[i-4] ^ ref_seq[i-3] ^ ref_seq[i-2];

    //             rst   zero  gap   n     fe  fc  lock  bits  errs pul los
    segs[0]  = mk(1'b1, 1'b0, 1'b0, 23,   0,  0, 1'b0, 0,    0,   0,  0); // one short of lock
    segs[1]  = mk(1'b0, 1'b0, 1'b0, 1,    0,  0, 1'b1, 0,    0,   0,  0); // 24th bit locks
    segs[2]  = mk(1'b0, 1'b0, 1'b0, 1000, 0,  0, 1'b1, 1000, 0,   0,  0); // clean stream
    segs[3]  = mk(1'b0, 1'b0, 1'b0, 50,   10, 1, 1'b1, 1050, 1,   1,  0); // single error
    segs[4]  = mk(1'b0, 1'b0, 1'b0, 100,  0,  0, 1'b1, 1150, 1,   0,  0); // no follow-on
    segs[5]  = mk(1'b1, 1'b0, 1'b0, 24,   0,  0, 1'b1, 0,    0,   0,  0);
    segs[6]  = mk(1'b0, 1'b0, 1'b0, 16,   2,  8, 1'b0, 16,   8,   8,  1); // 8 errs -> loss
    segs[7]  = mk(1'b0, 1'b0, 1'b0, 23,   0,  0, 1'b0, 16,   8,   0,  0);
    segs[8]  = mk(1'b0, 1'b0, 1'b0, 1,    0,  0, 1'b1, 16,   8,   0,  0); // relock
    segs[9]  = mk(1'b0, 1'b0, 1'b0, 10,   0,  0, 1'b1, 26,   8,   0,  0);
    segs[10] = mk(1'b1, 1'b0, 1'b0, 24,   0,  0, 1'b1, 0,    0,   0,  0);
    segs[11] = mk(1'b0, 1'b0, 1'b0, 64,   9,  7, 1'b1, 64,   7,   7,  0); // 7 in window 1
    segs[12] = mk(1'b0, 1'b0, 1'b0, 64,   9,  7, 1'b1, 128,  14,  7,  0); // 7 in window 2
    segs[13] = mk(1'b0, 1'b0, 1'b0, 64,   8,  8, 1'b0, 192,  22,  8,  1); // 8th on wrap bit
    segs[14] = mk(1'b1, 1'b1, 1'b0, 500,  0,  0, 1'b0, 0,    0,   0,  0); // all-zero input
    segs[15] = mk(1'b1, 1'b0, 1'b1, 23,   0,  0, 1'b0, 0,    0,   0,  0); // gapped valid
    segs[16] = mk(1'b0, 1'b0, 1'b1, 1,    0,  0, 1'b1, 0,    0,   0,  0);
    segs[17] = mk(1'b0, 1'b0, 1'b1, 1000, 0,  0, 1'b1, 1000, 0,   0,  0);

    for (int k = 0; k < NSEG; k++) run_seg(k, segs[k]);

    // clr_cnt together with an errored bit: clear wins, pulse still fires.
    next_bit(d);
    tick(1'b1, ~d, 1'b1);
    check("clr err_pulse", 64'(err_pulse), 64'd1);
    check("clr err_cnt",   64'(err_cnt),   64'd0);
    check("clr bit_cnt",   64'(bit_cnt),   64'd0);
    check("clr locked",    64'(locked),    64'd1);
    next_bit(d);
    tick(1'b1, d, 1'b0);
    check("post clr bit_cnt",   64'(bit_cnt),   64'd1);
    check("post clr err_cnt",   64'(err_cnt),   64'd0);
    check("post clr err_pulse", 64'(err_pulse), 64'd0);

    // Asynchronous reset between clock edges while an error pulse is high.
    next_bit(d);
    tick(1'b1, ~d, 1'b0);
    check("pre rst err_pulse", 64'(err_pulse), 64'd1);
    check("pre rst err_cnt",   64'(err_cnt),   64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async locked",    64'(locked),    64'd0);
    check("async err_pulse", 64'(err_pulse), 64'd0);
    check("async sync_loss", 64'(sync_loss), 64'd0);
    check("async bit_cnt",   64'(bit_cnt),   64'd0);
    check("async err_cnt",   64'(err_cnt),   64'd0);
    @(negedge sclk);
    rst_n = 1'b1;
    for (int i = 0; i < 23; i++) begin
      next_bit(d);
      tick(1'b1, d, 1'b0);
    end
    check("reacq 23 locked", 64'(locked), 64'd0);
    next_bit(d);
    tick(1'b1, d, 1'b0);
    check("reacq 24 locked", 64'(locked), 64'd1);
    for (int i = 0; i < 5; i++) begin
      next_bit(d);
      tick(1'b1, d, 1'b0);
    end
    check("reacq bit_cnt", 64'(bit_cnt), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
